// File: rtl/rmt_steer.sv
// Match-action steering stage: classifies each AXI-Stream frame on its first beat
// against a writable rule table, then forwards it with a per-frame tdest or drops it.
module rmt_steer #(
    parameter int              DATA_WIDTH   = 512,
    parameter int              KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int              USER_WIDTH   = 1,
    parameter int              DEST_WIDTH   = 2,
    parameter int              RULE_COUNT   = 4,
    parameter int              ETYPE_OFFSET = 12,
    parameter int              MAGIC_OFFSET = 42,
    parameter int              FUNC_OFFSET  = 44,
    parameter logic [15:0]     ETYPE_VALUE  = 16'h0800,
    parameter logic [15:0]     MAGIC_VALUE  = 16'hE1F0,
    parameter int              DEFAULT_DEST = 0,
    parameter bit              PASS_FOREIGN = 1'b0,
    localparam int             IDX_W        = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                  m_axis_tready,
    input  logic                  rule_wr_en,
    input  logic [IDX_W-1:0]      rule_wr_idx,
    input  logic                  rule_wr_valid,
    input  logic [15:0]           rule_wr_func,
    input  logic [DEST_WIDTH-1:0] rule_wr_dest,
    output logic [31:0]           stat_fwd_frames,
    output logic [31:0]           stat_drop_frames
);

    generate
        if (DATA_WIDTH < 8 * (FUNC_OFFSET + 2) || DATA_WIDTH < 8 * (MAGIC_OFFSET + 2) ||
            DATA_WIDTH < 8 * (ETYPE_OFFSET + 2)) begin : g_bad_width
            $error("rmt_steer: DATA_WIDTH too small for the header field offsets");
        end
        if (RULE_COUNT < 1 || RULE_COUNT > 16) begin : g_bad_rules
            $error("rmt_steer: RULE_COUNT must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                  state;
    logic [RULE_COUNT-1:0]   rule_valid;
    logic [15:0]             rule_func [RULE_COUNT];
    logic [DEST_WIDTH-1:0]   rule_dest [RULE_COUNT];

    logic [15:0]             etype;
    logic [15:0]             magic;
    logic [15:0]             func;
    logic                    hit;
    logic                    fwd;
    logic                    matched;
    logic [DEST_WIDTH-1:0]   match_dest;
    logic                    accept;

    // Handshake: a beat transfers on any edge where valid && ready. Input ready is
    // withheld only while the output register is full and stalled; DROP sinks freely.
    assign s_axis_tready = rst_n && ((state == ST_DROP) || !m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign etype = {s_axis_tdata[8*ETYPE_OFFSET +: 8], s_axis_tdata[8*(ETYPE_OFFSET+1) +: 8]};
    assign magic = {s_axis_tdata[8*MAGIC_OFFSET +: 8], s_axis_tdata[8*(MAGIC_OFFSET+1) +: 8]};
    assign func  = {s_axis_tdata[8*FUNC_OFFSET +: 8],  s_axis_tdata[8*(FUNC_OFFSET+1) +: 8]};
    assign hit   = (etype == ETYPE_VALUE) && (magic == MAGIC_VALUE);
    assign fwd   = hit || PASS_FOREIGN;

    // Lowest-index valid rule wins; the registered table makes same-cycle writes invisible.
    always_comb begin
        matched    = 1'b0;
        match_dest = DEST_WIDTH'(DEFAULT_DEST);
        for (int i = 0; i < RULE_COUNT; i++) begin
            if (!matched && rule_valid[i] && (rule_func[i] == func)) begin
                matched    = 1'b1;
                match_dest = rule_dest[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            m_axis_tdata     <= '0;
            m_axis_tkeep     <= '0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tlast     <= 1'b0;
            m_axis_tuser     <= '0;
            m_axis_tdest     <= '0;
            rule_valid       <= '0;
            rule_func        <= '{default: '0};
            rule_dest        <= '{default: '0};
            stat_fwd_frames  <= '0;
            stat_drop_frames <= '0;
        end else begin
            if (rule_wr_en && (32'(rule_wr_idx) < RULE_COUNT)) begin
                rule_valid[rule_wr_idx] <= rule_wr_valid;
                rule_func[rule_wr_idx]  <= rule_wr_func;
                rule_dest[rule_wr_idx]  <= rule_wr_dest;
            end

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (accept) begin
                unique case (state)
                    ST_IDLE: begin
                        if (fwd) begin
                            m_axis_tdata  <= s_axis_tdata;
                            m_axis_tkeep  <= s_axis_tkeep;
                            m_axis_tlast  <= s_axis_tlast;
                            m_axis_tuser  <= s_axis_tuser;
                            m_axis_tvalid <= 1'b1;
                            // tdest is latched here and left untouched for the rest of the frame.
                            m_axis_tdest  <= match_dest;
                            if (s_axis_tlast) stat_fwd_frames <= stat_fwd_frames + 32'd1;
                            else              state           <= ST_FWD;
                        end else begin
                            if (s_axis_tlast) stat_drop_frames <= stat_drop_frames + 32'd1;
                            else              state            <= ST_DROP;
                        end
                    end
                    ST_FWD: begin
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tkeep  <= s_axis_tkeep;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tuser  <= s_axis_tuser;
                        m_axis_tvalid <= 1'b1;
                        if (s_axis_tlast) begin
                            stat_fwd_frames <= stat_fwd_frames + 32'd1;
                            state           <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (s_axis_tlast) begin
                            stat_drop_frames <= stat_drop_frames + 32'd1;
                            state            <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rmt_steer.sv
// Directed plus random bench for rmt_steer: a beat scoreboard fed at input acceptance,
// drained by a negedge monitor, with frame statistics checked against a reference model.
module tb_rmt_steer;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int UW    = 1;
    localparam int DESTW = 2;
    localparam int RC    = 4;
    localparam int BW    = DW + KW + 1 + UW + DESTW;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic [UW-1:0]   m_axis_tuser;
    logic [DESTW-1:0] m_axis_tdest;
    logic            m_axis_tready;
    logic            rule_wr_en;
    logic [1:0]      rule_wr_idx;
    logic            rule_wr_valid;
    logic [15:0]     rule_wr_func;
    logic [DESTW-1:0] rule_wr_dest;
    logic [31:0]     stat_fwd_frames;
    logic [31:0]     stat_drop_frames;

    rmt_steer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(DESTW), .RULE_COUNT(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tdest(m_axis_tdest),
        .m_axis_tready(m_axis_tready),
        .rule_wr_en(rule_wr_en), .rule_wr_idx(rule_wr_idx), .rule_wr_valid(rule_wr_valid),
        .rule_wr_func(rule_wr_func), .rule_wr_dest(rule_wr_dest),
        .stat_fwd_frames(stat_fwd_frames), .stat_drop_frames(stat_drop_frames)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [BW-1:0]    exp_q[$];
    logic [BW-1:0]    mon_obs;
    logic [BW-1:0]    mon_exp;
    int               n_cmp = 0;
    int               n_err = 0;
    logic             m_rv [RC];
    logic [15:0]      m_rf [RC];
    logic [DESTW-1:0] m_rd [RC];
    bit               in_frame;
    bit               cur_fwd;
    logic [DESTW-1:0] cur_dest;
    int               exp_fwd;
    int               exp_drop;
    bit               rand_bp = 1'b0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < RC; i++) begin
            m_rv[i] = 1'b0;
            m_rf[i] = '0;
            m_rd[i] = '0;
        end
        in_frame = 1'b0;
        cur_fwd  = 1'b0;
        cur_dest = '0;
        exp_fwd  = 0;
        exp_drop = 0;
    endfunction

    function automatic void classify(input logic [DW-1:0] d, output bit fwd, output logic [DESTW-1:0] dest);
        logic [15:0] et, mg, fn;
        et   = {d[8*12 +: 8], d[8*13 +: 8]};
        mg   = {d[8*42 +: 8], d[8*43 +: 8]};
        fn   = {d[8*44 +: 8], d[8*45 +: 8]};
        fwd  = (et == 16'h0800) && (mg == 16'hE1F0);
        dest = '0;
        for (int i = RC - 1; i >= 0; i--) begin
            if (m_rv[i] && m_rf[i] == fn) dest = m_rd[i];
        end
    endfunction

    function automatic void model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                         input logic l, input logic [UW-1:0] u);
        if (!in_frame) classify(d, cur_fwd, cur_dest);
        if (cur_fwd) exp_q.push_back({d, k, l, u, cur_dest});
        if (l) begin
            in_frame = 1'b0;
            if (cur_fwd) exp_fwd++;
            else         exp_drop++;
        end else begin
            in_frame = 1'b1;
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [DW-1:0] make_beat(input logic [15:0] et, input logic [15:0] mg, input logic [15:0] fn);
        logic [DW-1:0] d;
        d = rand_data();
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
        d[8*42 +: 8] = mg[15:8];
        d[8*43 +: 8] = mg[7:0];
        d[8*44 +: 8] = fn[15:8];
        d[8*45 +: 8] = fn[7:0];
        return d;
    endfunction

    function automatic logic [KW-1:0] rand_keep();
        logic [KW-1:0] k;
        k = {$urandom, $urandom};
        if (k == '0) k = 1;
        return k;
    endfunction

    // monitor: a stalled beat must match the queue head; a transferring beat pops it
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid) begin
            chk("m_beat_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_obs = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest};
                if (m_axis_tready) begin
                    mon_exp = exp_q.pop_front();
                    chk("m_beat", mon_obs, mon_exp);
                end else begin
                    chk("m_hold", mon_obs, exp_q[0]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    // driver tasks (all called at posedge + 1)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [UW-1:0] u, output int waits);
        bit done;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                model_accept(d, k, l, u);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 500) begin
                    chk("s_ready_timeout", waits, 500);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [15:0] et, input logic [15:0] mg,
                              input logic [15:0] fn, input int gap_max, output int tot_waits);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int w;
        tot_waits = 0;
        for (int b = 0; b < len; b++) begin
            d = (b == 0) ? make_beat(et, mg, fn) : rand_data();
            k = (b == len - 1) ? rand_keep() : '1;
            send_beat(d, k, (b == len - 1), UW'($urandom_range(0, 1)), w);
            tot_waits += w;
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic write_rule(input logic [1:0] idx, input logic v, input logic [15:0] f, input logic [DESTW-1:0] dst);
        rule_wr_en    = 1'b1;
        rule_wr_idx   = idx;
        rule_wr_valid = v;
        rule_wr_func  = f;
        rule_wr_dest  = dst;
        @(posedge clk);
        #1;
        rule_wr_en = 1'b0;
        m_rv[idx]  = v;
        m_rf[idx]  = f;
        m_rd[idx]  = dst;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", (t < 300), 1);
    endtask

    initial begin
        int w;
        int base;
        logic [DW-1:0] b0, b1, b2;

        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        rule_wr_en = 1'b0; rule_wr_idx = '0; rule_wr_valid = 1'b0; rule_wr_func = '0; rule_wr_dest = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_m_valid", m_axis_tvalid, 0);
        chk("rst_m_data", m_axis_tdata, 0);
        chk("rst_m_dest", m_axis_tdest, 0);
        chk("rst_stat_fwd", stat_fwd_frames, 0);
        chk("rst_stat_drop", stat_drop_frames, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single-beat magic frame, empty rule table -> default dest
        send_frame(1, 16'h0800, 16'hE1F0, 16'h0001, 0, w);
        drain();
        chk("t1_stat_fwd", stat_fwd_frames, 1);

        // rule hit on a 3-beat frame
        write_rule(2'd0, 1'b1, 16'h0001, 2'd1);
        send_frame(3, 16'h0800, 16'hE1F0, 16'h0001, 0, w);
        drain();
        chk("t2_stat_fwd", stat_fwd_frames, 2);

        // foreign EtherType dropped, accepted back-to-back
        send_frame(3, 16'h86DD, 16'hE1F0, 16'h0001, 0, w);
        drain();
        chk("t3_drop_waits", w, 0);
        chk("t3_stat_drop", stat_drop_frames, 1);
        chk("t3_stat_fwd", stat_fwd_frames, 2);

        // output stall of 5 cycles mid-frame
        b0 = make_beat(16'h0800, 16'hE1F0, 16'h0001);
        send_beat(b0, '1, 1'b0, 1'b0, w);
        m_axis_tready = 1'b0;
        b1 = rand_data();
        s_axis_tdata = b1; s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tuser = 1'b1; s_axis_tvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_s_ready", s_axis_tready, 0);
            chk("t4_stall_m_valid", m_axis_tvalid, 1);
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        send_beat(b1, '1, 1'b0, 1'b1, w);
        send_beat(rand_data(), '1, 1'b0, 1'b0, w);
        send_beat(rand_data(), rand_keep(), 1'b1, 1'b0, w);
        drain();
        chk("t4_stat_fwd", stat_fwd_frames, 3);

        // rule rewrite during beat 2 does not affect the frame in flight
        b0 = make_beat(16'h0800, 16'hE1F0, 16'h0001);
        send_beat(b0, '1, 1'b0, 1'b0, w);
        rule_wr_en = 1'b1; rule_wr_idx = 2'd0; rule_wr_valid = 1'b1; rule_wr_func = 16'h0001; rule_wr_dest = 2'd2;
        send_beat(rand_data(), '1, 1'b0, 1'b1, w);
        rule_wr_en = 1'b0;
        m_rd[0] = 2'd2;
        send_beat(rand_data(), rand_keep(), 1'b1, 1'b0, w);
        send_frame(1, 16'h0800, 16'hE1F0, 16'h0001, 0, w);
        drain();
        chk("t5_stat_fwd", stat_fwd_frames, 5);

        // reset mid-frame: beat 2 of 4
        b0 = make_beat(16'h0800, 16'hE1F0, 16'h0001);
        b1 = rand_data();
        b2 = rand_data();
        send_beat(b0, '1, 1'b0, 1'b0, w);
        send_beat(b1, '1, 1'b0, 1'b0, w);
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_s_ready", s_axis_tready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("t6_m_valid", m_axis_tvalid, 0);
        chk("t6_stat_fwd", stat_fwd_frames, 0);
        chk("t6_stat_drop", stat_drop_frames, 0);
        @(posedge clk);
        #1;
        send_beat(b2, '1, 1'b0, 1'b0, w);
        send_beat(rand_data(), rand_keep(), 1'b1, 1'b0, w);
        send_frame(2, 16'h0800, 16'hE1F0, 16'h0001, 0, w);
        drain();
        chk("t6_remainder_drop", stat_drop_frames, exp_drop);
        chk("t6_rules_cleared_fwd", stat_fwd_frames, 1);

        // random stream of 100 frames with random backpressure and rule updates
        base = exp_fwd + exp_drop;
        rand_bp = 1'b1;
        for (int f = 0; f < 100; f++) begin
            if ($urandom_range(0, 4) == 0)
                write_rule(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                           16'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            send_frame($urandom_range(1, 4),
                       ($urandom_range(0, 3) == 0) ? 16'h86DD : 16'h0800,
                       ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'hE1F0,
                       16'($urandom_range(0, 7)), 2, w);
        end
        drain();
        chk("rand_stat_fwd", stat_fwd_frames, exp_fwd);
        chk("rand_stat_drop", stat_drop_frames, exp_drop);
        chk("rand_frame_total", stat_fwd_frames + stat_drop_frames - 32'(base), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
